// File: rtl/e1buf_pkg.sv
// Shared constants and types for the E1 tributary receive buffer controller.
package e1buf_pkg;

    localparam int NCHN    = 21;
    localparam int CHBIT   = 5;
    localparam int SEGBIT  = 4;
    localparam int WIDTH   = 8;
    localparam int ADDRBIT = CHBIT + SEGBIT;
    localparam int FILLBIT = SEGBIT + 1;

    localparam logic [WIDTH-1:0]   IDLE      = 8'hFF;
    localparam logic [FILLBIT-1:0] FILL_FULL = FILLBIT'(1 << SEGBIT);
    localparam logic [FILLBIT-1:0] FILL_HALF = FILLBIT'(1 << (SEGBIT - 1));
    localparam logic [SEGBIT-1:0]  PTR_HALF  = SEGBIT'(1 << (SEGBIT - 1));

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Array address of byte slot ptr inside channel chn's segment.
    function automatic logic [ADDRBIT-1:0] seg_addr(input logic [CHBIT-1:0]  chn,
                                                    input logic [SEGBIT-1:0] ptr);
        return {chn, ptr};
    endfunction

endpackage

// File: rtl/e1_chn_ptr.sv
// Per-channel circular segment bookkeeping: write/read pointers, fill level
// and the overflow/underflow stickies for one E1 channel.
module e1_chn_ptr
    import e1buf_pkg::*;
(
    input  logic              clk,
    input  logic              rst_,
    input  logic              wr_hit,
    input  logic              rd_hit,
    input  logic              flush_hit,
    input  logic              clr,
    output logic [SEGBIT-1:0] wptr,
    output logic [SEGBIT-1:0] rptr,
    output logic              full,
    output logic              empty,
    output logic              ovf,
    output logic              unf
);

    logic [SEGBIT-1:0]  wptr_q;
    logic [SEGBIT-1:0]  rptr_q;
    logic [FILLBIT-1:0] fill_q;
    logic [FILLBIT-1:0] fill_nxt;
    logic               wr_ok;
    logic               rd_ok;
    logic               ovf_q;
    logic               unf_q;

    // Both accept decisions look at the fill level before this clock, so a
    // same-cycle write cannot rescue a read of an empty segment.
    assign full  = (fill_q == FILL_FULL);
    assign empty = (fill_q == '0);
    assign wr_ok = wr_hit & ~full;
    assign rd_ok = rd_hit & ~empty;

    // Net fill change from accepted write and read.
    always_comb begin
        fill_nxt = fill_q;
        if (wr_ok && !rd_ok) begin
            fill_nxt = fill_q + FILLBIT'(1);
        end else if (rd_ok && !wr_ok) begin
            fill_nxt = fill_q - FILLBIT'(1);
        end
    end

    // Pointer and fill registers; a recentre replaces any same-cycle update
    // and leaves the write pointer where it was.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            wptr_q <= '0;
            rptr_q <= '0;
            fill_q <= '0;
        end else if (flush_hit) begin
            rptr_q <= wptr_q - PTR_HALF;
            fill_q <= FILL_HALF;
        end else begin
            if (wr_ok) begin
                wptr_q <= wptr_q + SEGBIT'(1);
            end
            if (rd_ok) begin
                rptr_q <= rptr_q + SEGBIT'(1);
            end
            fill_q <= fill_nxt;
        end
    end

    // Stickies: a same-cycle event beats the clear.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ovf_q <= (ovf_q & ~clr) | (wr_hit & full);
            unf_q <= (unf_q & ~clr) | (rd_hit & empty);
        end
    end

    assign wptr = wptr_q;
    assign rptr = rptr_q;
    assign ovf  = ovf_q;
    assign unf  = unf_q;

endmodule

// File: rtl/e1_rxbuf_ctl.sv
// Address/flow controller for the shared E1 tributary buffer. Sweeps the
// array with the idle pattern after reset, then steers demapper writes and
// desync reads into per-channel circular segments.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_INIT | writing IDLE to every array address, all traffic ignored
// ST_RUN  | normal operation until the next reset
module e1_rxbuf_ctl
    import e1buf_pkg::*;
(
    input  logic               clk,
    input  logic               rst_,
    input  logic               wr_vld,
    input  logic [CHBIT-1:0]   wr_chn,
    input  logic [WIDTH-1:0]   wr_dat,
    input  logic               rd_req,
    input  logic [CHBIT-1:0]   rd_chn,
    output logic               rd_vld,
    output logic [WIDTH-1:0]   rd_dat,
    input  logic               flush,
    input  logic [CHBIT-1:0]   flush_chn,
    input  logic               sticky_clr,
    output logic [NCHN-1:0]    ovf_stk,
    output logic [NCHN-1:0]    unf_stk,
    output logic               busy,
    input  logic [ADDRBIT-1:0] cpu_ra,
    output logic [WIDTH-1:0]   cpu_rdat,
    output logic [ADDRBIT-1:0] ram_wa,
    output logic               ram_we,
    output logic [WIDTH-1:0]   ram_di,
    output logic [ADDRBIT-1:0] ram_ra1,
    input  logic [WIDTH-1:0]   ram_do1,
    output logic [ADDRBIT-1:0] ram_ra2,
    input  logic [WIDTH-1:0]   ram_do2
);

    state_t             state_q;
    state_t             state_nxt;
    logic [ADDRBIT-1:0] cnt_q;
    logic               run;

    logic [NCHN-1:0]    wr_hit;
    logic [NCHN-1:0]    rd_hit;
    logic [NCHN-1:0]    flush_hit;
    logic [NCHN-1:0]    full_v;
    logic [NCHN-1:0]    empty_v;
    logic [SEGBIT-1:0]  wptr_a [NCHN];
    logic [SEGBIT-1:0]  rptr_a [NCHN];

    logic               wr_rng;
    logic               rd_rng;
    logic [SEGBIT-1:0]  wptr_sel;
    logic [SEGBIT-1:0]  rptr_sel;
    logic               full_sel;
    logic               empty_sel;
    logic               rd_vld_q;
    logic               empty_q;

    assign run    = (state_q == ST_RUN);
    assign busy   = ~run;
    assign wr_rng = (wr_chn < CHBIT'(NCHN));
    assign rd_rng = (rd_chn < CHBIT'(NCHN));

    // State register.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_q <= ST_INIT;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Leave the sweep once the last array address has been written.
    always_comb begin
        state_nxt = state_q;
        case (state_q)
            ST_INIT: if (cnt_q == '1) state_nxt = ST_RUN;
            ST_RUN:  state_nxt = ST_RUN;
            default: state_nxt = ST_INIT;
        endcase
    end

    // Sweep address counter, advancing only while sweeping.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            cnt_q <= '0;
        end else if (state_q == ST_INIT) begin
            cnt_q <= cnt_q + ADDRBIT'(1);
        end
    end

    genvar c;
    generate
        for (c = 0; c < NCHN; c++) begin : g_chn
            assign wr_hit[c]    = run & wr_vld & (wr_chn == CHBIT'(c));
            assign rd_hit[c]    = run & rd_req & (rd_chn == CHBIT'(c));
            assign flush_hit[c] = run & flush  & (flush_chn == CHBIT'(c));

            e1_chn_ptr u_chn_ptr (
                .clk       (clk),
                .rst_      (rst_),
                .wr_hit    (wr_hit[c]),
                .rd_hit    (rd_hit[c]),
                .flush_hit (flush_hit[c]),
                .clr       (sticky_clr),
                .wptr      (wptr_a[c]),
                .rptr      (rptr_a[c]),
                .full      (full_v[c]),
                .empty     (empty_v[c]),
                .ovf       (ovf_stk[c]),
                .unf       (unf_stk[c])
            );
        end
    endgenerate

    // Pick out the addressed channel's pointer and status; out-of-range
    // channels see zeros and are blocked from the array separately.
    always_comb begin
        wptr_sel  = '0;
        rptr_sel  = '0;
        full_sel  = 1'b0;
        empty_sel = 1'b0;
        for (int i = 0; i < NCHN; i++) begin
            if (wr_chn == CHBIT'(i)) begin
                wptr_sel = wptr_a[i];
                full_sel = full_v[i];
            end
            if (rd_chn == CHBIT'(i)) begin
                rptr_sel  = rptr_a[i];
                empty_sel = empty_v[i];
            end
        end
    end

    // Array write port: sweep owns it during init, demapper afterwards.
    always_comb begin
        ram_we = 1'b0;
        ram_wa = seg_addr(wr_chn, wptr_sel);
        ram_di = wr_dat;
        if (!run) begin
            ram_we = 1'b1;
            ram_wa = cnt_q;
            ram_di = IDLE;
        end else begin
            ram_we = wr_vld & wr_rng & ~full_sel;
        end
    end

    assign ram_ra1 = seg_addr(rd_chn, rptr_sel);

    // Read response pipeline, aligned with the array's one-cycle read latency.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            rd_vld_q <= 1'b0;
            empty_q  <= 1'b0;
        end else begin
            rd_vld_q <= run & rd_req & rd_rng;
            empty_q  <= empty_sel;
        end
    end

    assign rd_vld = rd_vld_q;
    assign rd_dat = empty_q ? IDLE : ram_do1;

    assign ram_ra2  = cpu_ra;
    assign cpu_rdat = ram_do2;

endmodule

// File: tb/tb_e1_rxbuf_ctl.sv
module tb_e1_rxbuf_ctl;

    logic        clk = 1'b0;
    logic        rst_ = 1'b0;
    logic        wr_vld = 1'b0;
    logic [4:0]  wr_chn = '0;
    logic [7:0]  wr_dat = '0;
    logic        rd_req = 1'b0;
    logic [4:0]  rd_chn = '0;
    logic        rd_vld;
    logic [7:0]  rd_dat;
    logic        flush = 1'b0;
    logic [4:0]  flush_chn = '0;
    logic        sticky_clr = 1'b0;
    logic [20:0] ovf_stk;
    logic [20:0] unf_stk;
    logic        busy;
    logic [8:0]  cpu_ra = '0;
    logic [7:0]  cpu_rdat;
    logic [8:0]  ram_wa;
    logic        ram_we;
    logic [7:0]  ram_di;
    logic [8:0]  ram_ra1;
    logic [7:0]  ram_do1;
    logic [8:0]  ram_ra2;
    logic [7:0]  ram_do2;

    e1_rxbuf_ctl dut (
        .clk(clk), .rst_(rst_),
        .wr_vld(wr_vld), .wr_chn(wr_chn), .wr_dat(wr_dat),
        .rd_req(rd_req), .rd_chn(rd_chn), .rd_vld(rd_vld), .rd_dat(rd_dat),
        .flush(flush), .flush_chn(flush_chn), .sticky_clr(sticky_clr),
        .ovf_stk(ovf_stk), .unf_stk(unf_stk), .busy(busy),
        .cpu_ra(cpu_ra), .cpu_rdat(cpu_rdat),
        .ram_wa(ram_wa), .ram_we(ram_we), .ram_di(ram_di),
        .ram_ra1(ram_ra1), .ram_do1(ram_do1),
        .ram_ra2(ram_ra2), .ram_do2(ram_do2)
    );

    always #5 clk = ~clk;

    // 2R/1W register array: registered reads, one clock latency.
    logic [7:0] mem [512];
    int         wcount [512];
    bit         count_en = 0;
    always @(posedge clk) begin
        if (ram_we) begin
            mem[ram_wa] <= ram_di;
            if (count_en) wcount[ram_wa] <= wcount[ram_wa] + 1;
        end
        ram_do1 <= mem[ram_ra1];
        ram_do2 <= mem[ram_ra2];
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: each channel is a 16-byte ring image plus a write
    // position and an occupancy; the oldest unread byte sits occupancy slots
    // behind the write position.
    logic [7:0]  seg [21][16];
    int          m_wp [21];
    int          m_fill [21];
    logic [20:0] m_ovf = '0;
    logic [20:0] m_unf = '0;
    bit          model_run = 0;
    int          cyc = 0;

    typedef struct { int cyc; logic [7:0] dat; } exp_t;
    exp_t exp_q[$];

    task automatic model_step();
        int  fr, fw, owp, wc, rc, fc;
        bit  acc, take;
        exp_t e;
        acc = 0; take = 0; owp = 0;
        wc = int'(wr_chn); rc = int'(rd_chn); fc = int'(flush_chn);
        if (flush && fc < 21) owp = m_wp[fc];
        if (sticky_clr) begin m_ovf = '0; m_unf = '0; end
        if (rd_req && rc < 21) begin
            fr = m_fill[rc];
            e.cyc = cyc;
            if (fr == 0) begin
                e.dat = 8'hFF;
                m_unf[rc] = 1'b1;
            end else begin
                e.dat = seg[rc][(m_wp[rc] - fr) & 15];
                take = 1;
            end
            exp_q.push_back(e);
        end
        if (wr_vld && wc < 21) begin
            fw = m_fill[wc];
            if (fw == 16) m_ovf[wc] = 1'b1;
            else begin
                seg[wc][m_wp[wc]] = wr_dat;
                acc = 1;
            end
        end
        if (acc) begin
            m_wp[wc] = (m_wp[wc] + 1) % 16;
            m_fill[wc]++;
        end
        if (take) m_fill[rc]--;
        if (flush && fc < 21) begin
            m_wp[fc] = owp;
            m_fill[fc] = 8;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        if (model_run) model_step();
        #1;
    endtask

    task automatic idle_in();
        wr_vld = 0; rd_req = 0; flush = 0; sticky_clr = 0;
    endtask

    task automatic do_wr(input int c, input logic [7:0] d);
        idle_in(); wr_vld = 1; wr_chn = 5'(c); wr_dat = d; tick(); idle_in();
    endtask

    task automatic do_rd(input int c);
        idle_in(); rd_req = 1; rd_chn = 5'(c); tick(); idle_in();
    endtask

    function automatic logic [4:0] pick_chn();
        int v;
        v = $urandom_range(0, 9);
        case (v)
            0, 1:    return 5'd1;
            2, 3:    return 5'd2;
            4, 5:    return 5'd20;
            6:       return 5'd0;
            7:       return 5'd21;
            8:       return 5'd31;
            default: return 5'($urandom_range(0, 20));
        endcase
    endfunction

    task automatic rand_in();
        wr_vld     = ($urandom_range(0, 9) < 6);
        wr_chn     = pick_chn();
        wr_dat     = 8'($urandom_range(0, 255));
        rd_req     = ($urandom_range(0, 9) < 5);
        rd_chn     = pick_chn();
        flush      = ($urandom_range(0, 49) == 0);
        flush_chn  = pick_chn();
        sticky_clr = ($urandom_range(0, 19) == 0);
    endtask

    // Monitor: every presented read is matched against the scoreboard,
    // including the cycle it was due in; stickies are followed each cycle.
    bit mon_en = 0;
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (rd_vld === 1'b1) begin
                    if (exp_q.size() == 0) chk("rd_vld_unexpected", 1, 0);
                    else begin
                        e = exp_q.pop_front();
                        chk("rd_cycle", cyc, e.cyc);
                        chk("rd_dat", rd_dat, e.dat);
                    end
                end
                chk("ovf_stk", ovf_stk, m_ovf);
                chk("unf_stk", unf_stk, m_unf);
            end
        end
    end

    initial begin
        int k, bad;
        bit found;
        for (int c = 0; c < 21; c++) begin
            m_wp[c] = 0; m_fill[c] = 0;
            for (int s = 0; s < 16; s++) seg[c][s] = 8'hFF;
        end
        for (int a = 0; a < 512; a++) wcount[a] = 0;

        #2;
        chk("rst_busy", busy, 1);
        chk("rst_ram_we", ram_we, 1);
        chk("rst_ram_wa", ram_wa, 0);
        chk("rst_ram_di", ram_di, 8'hFF);
        chk("rst_rd_vld", rd_vld, 0);
        chk("rst_ovf", ovf_stk, 0);
        chk("rst_unf", unf_stk, 0);
        mon_en = 1;
        #10 rst_ = 1;

        // reset in the middle of the sweep
        found = 0;
        for (int i = 0; i < 300 && !found; i++) begin
            tick();
            if (ram_wa == 9'd100) found = 1;
        end
        chk("sweep_reach_100", found, 1);
        rst_ = 0;
        #1;
        chk("restart_ram_wa", ram_wa, 0);
        chk("restart_busy", busy, 1);
        rst_ = 1;

        // full sweep with traffic that must be ignored
        count_en = 1;
        for (k = 1; k <= 512; k++) begin
            rand_in();
            tick();
            if (k == 511) chk("busy_at_511", busy, 1);
            if (k == 512) chk("busy_at_512", busy, 0);
        end
        idle_in();
        count_en = 0;
        model_run = 1;
        bad = 0;
        for (int a = 0; a < 512; a++)
            if (wcount[a] != 1 || mem[a] !== 8'hFF) bad++;
        chk("init_sweep_bad_addrs", bad, 0);

        cpu_ra = 9'h155;
        tick();
        chk("cpu_peek_155", cpu_rdat, 8'hFF);

        // ch3: three bytes in, three out, then underflow
        do_wr(3, 8'h11); do_wr(3, 8'h22); do_wr(3, 8'h33);
        do_rd(3); do_rd(3); do_rd(3); do_rd(3);
        tick();
        chk("ch3_unf", unf_stk[3], 1);
        cpu_ra = 9'h030;
        tick();
        chk("cpu_peek_030", cpu_rdat, 8'h11);
        idle_in(); sticky_clr = 1; tick(); idle_in();

        // ch20: overflow on the 17th byte, pointers wrap
        for (int i = 0; i <= 16; i++) do_wr(20, 8'(i));
        tick();
        chk("ch20_ovf", ovf_stk[20], 1);
        for (int i = 0; i < 16; i++) do_rd(20);
        wr_chn = 5'd20; rd_chn = 5'd20;
        #1;
        chk("ch20_wa_wrap", ram_wa, 9'h140);
        chk("ch20_ra_wrap", ram_ra1, 9'h140);

        // ch5: simultaneous write and read on an empty channel
        idle_in();
        wr_vld = 1; wr_chn = 5'd5; wr_dat = 8'hA5; rd_req = 1; rd_chn = 5'd5;
        tick(); idle_in();
        do_rd(5);
        tick();

        // ch7: recentre at wptr 9, then underflow racing a sticky clear
        for (int i = 0; i < 9; i++) do_wr(7, 8'h70 + 8'(i));
        idle_in(); flush = 1; flush_chn = 5'd7; tick(); idle_in();
        rd_chn = 5'd7;
        #1;
        chk("ch7_rptr_after_flush", ram_ra1, 9'h071);
        for (int i = 0; i < 8; i++) do_rd(7);
        idle_in(); rd_req = 1; rd_chn = 5'd7; sticky_clr = 1; tick(); idle_in();
        chk("ch7_unf_beats_clr", unf_stk[7], 1);

        // out-of-range channels
        idle_in(); wr_vld = 1; wr_chn = 5'd21; wr_dat = 8'h5A;
        #1;
        chk("oor_ram_we", ram_we, 0);
        tick();
        idle_in(); rd_req = 1; rd_chn = 5'd31; tick(); idle_in();
        chk("oor_rd_vld", rd_vld, 0);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            rand_in();
            tick();
        end
        idle_in();
        tick(); tick(); tick();
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
